// File: rtl/ex_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_alu_unit
// Brief    : Execute-stage ALU with built-in ALU-control decode, RV32I + M ops,
//            two-stage multiply and iterative restoring divide with stall.
// Revision : 1.0 - initial release
// ============================================================================
module ex_alu_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    input  logic [1:0]      alu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int C_SHW = $clog2(XLEN);
    localparam int C_CW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] C_SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    function automatic op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    function automatic op_e m_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return OP_MUL;
            3'b001:  return OP_MULH;
            3'b010:  return OP_MULHSU;
            3'b011:  return OP_MULHU;
            3'b100:  return OP_DIV;
            3'b101:  return OP_DIVU;
            3'b110:  return OP_REM;
            default: return OP_REMU;
        endcase
    endfunction

    state_e                state_q, state_d;
    logic [C_CW-1:0]       cnt_q, cnt_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;
    logic                  valid_q, valid_d;
    logic [2*XLEN-1:0]     prod_q, prod_d;
    logic                  mulhi_q, mulhi_d;
    logic [XLEN-1:0]       quo_q, quo_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [XLEN-1:0]       dvs_q, dvs_d;
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic                  isrem_q, isrem_d;

    logic [6:0]            w_funct7;
    logic [2:0]            w_funct3;
    op_e                   w_op;
    logic                  w_dec_illegal;
    logic                  w_is_mul, w_is_div, w_div_signed, w_is_rem;
    logic                  w_div_zero, w_div_ovf, w_fast, w_long;
    logic [C_SHW-1:0]      w_shamt;
    logic [XLEN-1:0]       w_alu_res, w_fast_res;
    logic [2*XLEN-1:0]     w_mul_a, w_mul_b;
    logic [XLEN-1:0]       w_a_mag, w_b_mag;
    logic [XLEN:0]         w_rem_sh, w_diff;
    logic                  w_qbit;
    logic [XLEN-1:0]       w_rem_nx, w_quo_nx, w_div_res;
    logic                  unused_inst;

    assign w_funct7    = inst[31:25];
    assign w_funct3    = inst[14:12];
    assign unused_inst = ^{inst[24:15], inst[11:0]};
    assign w_shamt     = src_b[C_SHW-1:0];

    always_comb begin
        w_op          = OP_ADD;
        w_dec_illegal = 1'b0;
        unique case (alu_op)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (w_funct7 == 7'b0000000)
                    w_op = base_op(w_funct3);
                else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000)
                    w_op = OP_SUB;
                else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101)
                    w_op = OP_SRA;
                else if (w_funct7 == 7'b0000001)
                    w_op = m_op(w_funct3);
                else
                    w_dec_illegal = 1'b1;
            end
            default: begin
                // Immediate forms ignore funct7 except to pick SRAI over SRLI
                w_op = base_op(w_funct3);
                if (w_funct3 == 3'b101 && w_funct7 == 7'b0100000)
                    w_op = OP_SRA;
            end
        endcase
    end

    assign w_is_mul     = (w_op == OP_MUL) || (w_op == OP_MULH) ||
                          (w_op == OP_MULHSU) || (w_op == OP_MULHU);
    assign w_is_div     = (w_op == OP_DIV) || (w_op == OP_DIVU) ||
                          (w_op == OP_REM) || (w_op == OP_REMU);
    assign w_div_signed = (w_op == OP_DIV) || (w_op == OP_REM);
    assign w_is_rem     = (w_op == OP_REM) || (w_op == OP_REMU);
    assign w_div_zero   = (src_b == '0);
    assign w_div_ovf    = w_div_signed && (src_a == C_SMIN) && (src_b == '1);
    assign w_fast       = w_div_zero || w_div_ovf;
    assign w_long       = in_valid && (w_is_mul || (w_is_div && !w_fast));

    always_comb begin
        if (w_div_zero)
            w_fast_res = w_is_rem ? src_a : '1;
        else
            w_fast_res = w_is_rem ? '0 : src_a;
    end

    always_comb begin
        w_alu_res = src_a + src_b;
        case (w_op)
            OP_SUB:  w_alu_res = src_a - src_b;
            OP_SLL:  w_alu_res = src_a << w_shamt;
            OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            OP_XOR:  w_alu_res = src_a ^ src_b;
            OP_SRL:  w_alu_res = src_a >> w_shamt;
            OP_SRA:  w_alu_res = $signed(src_a) >>> w_shamt;
            OP_OR:   w_alu_res = src_a | src_b;
            OP_AND:  w_alu_res = src_a & src_b;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: w_alu_res = w_fast_res;
            default: ;
        endcase
    end

    // Extending to 2*XLEN makes a truncated product exact for every sign mix
    assign w_mul_a = {{XLEN{src_a[XLEN-1] && (w_op == OP_MULH || w_op == OP_MULHSU)}}, src_a};
    assign w_mul_b = {{XLEN{src_b[XLEN-1] && (w_op == OP_MULH)}}, src_b};

    assign w_a_mag = (w_div_signed && src_a[XLEN-1]) ? -src_a : src_a;
    assign w_b_mag = (w_div_signed && src_b[XLEN-1]) ? -src_b : src_b;

    assign w_rem_sh  = {rem_q, quo_q[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, dvs_q};
    assign w_qbit    = ~w_diff[XLEN];
    assign w_rem_nx  = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nx  = {quo_q[XLEN-2:0], w_qbit};
    assign w_div_res = isrem_q ? (negr_q ? -w_rem_nx : w_rem_nx)
                               : (negq_q ? -w_quo_nx : w_quo_nx);

    assign stall = !flush && (((state_q == S_IDLE) && w_long) ||
                              ((state_q == S_DIV) && (cnt_q != '0)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        valid_d   = 1'b0;
        prod_d    = prod_q;
        mulhi_d   = mulhi_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        isrem_d   = isrem_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_is_mul) begin
                            prod_d  = w_mul_a * w_mul_b;
                            mulhi_d = (w_op != OP_MUL);
                            state_d = S_MUL;
                        end else if (w_is_div && !w_fast) begin
                            quo_d   = w_a_mag;
                            rem_d   = '0;
                            dvs_d   = w_b_mag;
                            negq_d  = w_div_signed && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                            negr_d  = w_div_signed && src_a[XLEN-1];
                            isrem_d = w_is_rem;
                            cnt_d   = C_CW'(XLEN-1);
                            state_d = S_DIV;
                        end else begin
                            result_d  = w_alu_res;
                            illegal_d = w_dec_illegal;
                            valid_d   = 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    result_d  = mulhi_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
                    illegal_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = S_IDLE;
                end
                S_DIV: begin
                    quo_d = w_quo_nx;
                    rem_d = w_rem_nx;
                    if (cnt_q == '0) begin
                        result_d  = w_div_res;
                        illegal_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - C_CW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // zero only follows result when a new result is actually written
        if (valid_d)
            zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
            prod_q    <= '0;
            mulhi_q   <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            isrem_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            valid_q   <= valid_d;
            prod_q    <= prod_d;
            mulhi_q   <= mulhi_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            isrem_q   <= isrem_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
`default_nettype wire
